read_cache: RTL
===============

READ_CACHE -- requirements
Module: read_cache

Interface
REQ-001 Parameters: DATA_WIDTH, 64, word width; ADDR_WIDTH, 64, address width; CHUNKS_LOG, 4, log2 words per line; SETS_LOG, 6, log2 sets (direct-mapped).
REQ-002 Ports, listed as name, direction, width, meaning:
- clk, in, 1, single clock; reset, in, 1, asynchronous active-high reset.
- req_valid, in, 1, CPU read request; req_addr, in, ADDR_WIDTH, byte address; req_ready, out, 1, request accepted when high with req_valid.
- resp_valid, out, 1, read data valid; resp_data, out, DATA_WIDTH, word at req_addr; resp_ready, in, 1, consumer accepts.
- command_valid, out, 1, line fetch request to bus; command_store, out, 1, tied 0; command_rready, out, 1, ready for line; command_addr, out, ADDR_WIDTH, line-aligned address; data_in, out, DATA_WIDTH*2^CHUNKS_LOG, tied 0.
- bus_valid, in, 1, line delivered; bus_ready, in, 1, bus idle (informational); data_out, in, DATA_WIDTH*2^CHUNKS_LOG, fetched line, word 0 at bits [DATA_WIDTH-1:0].
- invalidate, in, 1, snoop invalidate pulse; invalidate_addr, in, ADDR_WIDTH, snooped address.

Function
REQ-003 Address split: offset = log2(DATA_WIDTH/8)+CHUNKS_LOG LSBs (word select = upper CHUNKS_LOG offset bits), index = next SETS_LOG bits, tag = remaining MSBs.
REQ-004 State machine, states IDLE, LOOKUP, MISS, RESP; encoding from package.
REQ-005 IDLE: req_ready=1; on req_valid, latch req_addr, go LOOKUP; else stay.
REQ-006 LOOKUP: hit = valid[index] and tag match; hit -> latch selected word, go RESP; miss -> go MISS.
REQ-007 MISS: command_valid=1 and command_rready=1, command_addr = latched address with offset bits zeroed; on bus_valid, write data_out into line, set tag and valid, latch requested word from data_out, go RESP.
REQ-008 command_valid SHALL be 0 in the cycle after bus_valid is seen, so the bus does not re-issue the fetch.
REQ-009 RESP: resp_valid=1, resp_data stable; on resp_ready go IDLE; else hold.
REQ-010 Latency: hit, accept at cycle T, resp_valid at T+2; miss, resp_valid in the cycle after bus_valid.
REQ-011 req_ready=0 in all states except IDLE; only one request is outstanding.
REQ-012 Invalidate applies in every state: if valid[index(invalidate_addr)] and the tag matches, clear valid at the next edge.
REQ-013 Invalidate in the same cycle as a LOOKUP to the matching line: treat as miss.
REQ-014 Invalidate in the same cycle as a fill of the matching line: write data and tag but leave valid=0; the requester still receives the fetched word.
REQ-015 Invalidate to a non-matching tag or an invalid line: no effect.

Reset
REQ-016 Asynchronous, active-high: state=IDLE, all valid bits 0, latched address and word 0.
REQ-017 During reset all outputs are 0 except req_ready, which is 0 while reset is asserted and 1 in the first IDLE cycle after release.
REQ-018 Reset mid-miss abandons the fetch; command_valid drops immediately; tag/data arrays need no reset.

Structure
REQ-019 Package cache_pkg: state enum, localparams OFFSET_BITS, INDEX_BITS, TAG_BITS, LINE_WIDTH.
REQ-020 One sub-module, cache_line_store: tag/valid/data arrays with a combinational read port, a write port for fills, and a clear port for invalidates.

Verification
REQ-021 Cold read 0x1000 -> miss; command_valid with command_addr=0x1000; bus returns line with word k=0xA0+k -> resp_data=0xA0 one cycle after bus_valid.
REQ-022 Re-read 0x1008 after REQ-021 -> hit, no command_valid, resp_data=0xA1 at T+2.
REQ-023 Read 0x1000 after invalidate 0x1000 -> miss, new fetch issued; invalidate 0x3000 (other tag) -> 0x1000 still hits.
REQ-024 Conflict: 0x1000 then 0x3000 (same index, SETS_LOG=6) -> both miss; 0x1000 misses again afterwards.
REQ-025 resp_ready low for 5 cycles -> resp_valid and resp_data held; req_ready=0 throughout.
REQ-026 Invalidate 0x1000 in fill cycle -> word returned; next read 0x1000 misses. Reset in MISS -> command_valid=0, state IDLE.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped read cache.
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOOKUP = 2'd1,
    MISS   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Byte-offset plus word-select bits within one line
  function automatic int unsigned offset_bits(input int unsigned data_width,
                                              input int unsigned chunks_log);
    return int'($clog2(data_width / 8)) + chunks_log;
  endfunction

  localparam int unsigned DEF_DATA_WIDTH = 64;
  localparam int unsigned DEF_ADDR_WIDTH = 64;
  localparam int unsigned DEF_CHUNKS_LOG = 4;
  localparam int unsigned DEF_SETS_LOG   = 6;

  localparam int unsigned OFFSET_BITS = offset_bits(DEF_DATA_WIDTH, DEF_CHUNKS_LOG);
  localparam int unsigned INDEX_BITS  = DEF_SETS_LOG;
  localparam int unsigned TAG_BITS    = DEF_ADDR_WIDTH - OFFSET_BITS - INDEX_BITS;
  localparam int unsigned LINE_WIDTH  = DEF_DATA_WIDTH << DEF_CHUNKS_LOG;

endpackage

// File: rtl/cache_line_store.sv
// Tag/valid/data arrays: combinational read, fill write, snoop clear.
module cache_line_store #(
  parameter int unsigned IDX_W  = 6,
  parameter int unsigned TAG_W  = 51,
  parameter int unsigned LINE_W = 1024
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_index,
  output logic              rd_valid,
  output logic [TAG_W-1:0]  rd_tag,
  output logic [LINE_W-1:0] rd_line,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_index,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [LINE_W-1:0] wr_line,
  input  logic              wr_valid,
  input  logic              clr_en,
  input  logic [IDX_W-1:0]  clr_index,
  input  logic [TAG_W-1:0]  clr_tag
);

  localparam int unsigned SETS = 1 << IDX_W;

  logic [SETS-1:0]   valid;
  logic [TAG_W-1:0]  tags  [SETS];
  logic [LINE_W-1:0] lines [SETS];

  assign rd_valid = valid[rd_index];
  assign rd_tag   = tags[rd_index];
  assign rd_line  = lines[rd_index];

  // A fill to the same set overrides a concurrent clear (last assignment wins)
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid <= '0;
    end else begin
      if (clr_en && valid[clr_index] && (tags[clr_index] == clr_tag))
        valid[clr_index] <= 1'b0;
      if (wr_en)
        valid[wr_index] <= wr_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tags[wr_index]  <= wr_tag;
      lines[wr_index] <= wr_line;
    end
  end

endmodule

// File: rtl/read_cache.sv
// Direct-mapped, blocking read cache with line fill from the bus and snoop invalidate.
module read_cache
  import cache_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned CHUNKS_LOG = DEF_CHUNKS_LOG,
  parameter int unsigned SETS_LOG   = DEF_SETS_LOG
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  req_valid,
  input  logic [ADDR_WIDTH-1:0]                 req_addr,
  output logic                                  req_ready,
  output logic                                  resp_valid,
  output logic [DATA_WIDTH-1:0]                 resp_data,
  input  logic                                  resp_ready,
  output logic                                  command_valid,
  output logic                                  command_store,
  output logic                                  command_rready,
  output logic [ADDR_WIDTH-1:0]                 command_addr,
  output logic [(DATA_WIDTH << CHUNKS_LOG)-1:0] data_in,
  input  logic                                  bus_valid,
  input  logic                                  bus_ready,
  input  logic [(DATA_WIDTH << CHUNKS_LOG)-1:0] data_out,
  input  logic                                  invalidate,
  input  logic [ADDR_WIDTH-1:0]                 invalidate_addr
);

  localparam int unsigned OFF_W  = offset_bits(DATA_WIDTH, CHUNKS_LOG);
  localparam int unsigned IDX_W  = SETS_LOG;
  localparam int unsigned TAG_W  = ADDR_WIDTH - OFF_W - IDX_W;
  localparam int unsigned LINE_W = DATA_WIDTH << CHUNKS_LOG;
  localparam int unsigned WSH    = $clog2(DATA_WIDTH);

  state_t                  state, state_next;
  logic [ADDR_WIDTH-1:0]   addr, addr_next;
  logic [DATA_WIDTH-1:0]   word, word_next;
  logic                    ready_next, resp_next, cmd_next;
  logic                    fill, fill_valid;

  logic [IDX_W-1:0]        idx, inv_idx;
  logic [TAG_W-1:0]        tag, inv_tag;
  logic [CHUNKS_LOG-1:0]   wsel;
  logic                    rd_valid, hit, inv_same;
  logic [TAG_W-1:0]        rd_tag;
  logic [LINE_W-1:0]       rd_line;
  logic                    unused_bits;

  function automatic logic [DATA_WIDTH-1:0] pick(input logic [LINE_W-1:0] line,
                                                 input logic [CHUNKS_LOG-1:0] w);
    return DATA_WIDTH'(line >> {w, WSH'(0)});
  endfunction

  assign idx     = addr[OFF_W +: IDX_W];
  assign tag     = addr[OFF_W+IDX_W +: TAG_W];
  assign wsel    = addr[OFF_W-CHUNKS_LOG +: CHUNKS_LOG];
  assign inv_idx = invalidate_addr[OFF_W +: IDX_W];
  assign inv_tag = invalidate_addr[OFF_W+IDX_W +: TAG_W];

  // A snoop to the line being looked up or filled wins over the valid bit
  assign inv_same = invalidate && (inv_idx == idx) && (inv_tag == tag);
  assign hit      = rd_valid && (rd_tag == tag) && !inv_same;

  assign resp_data      = word;
  assign command_rready = command_valid;
  assign command_store  = 1'b0;
  assign command_addr   = {addr[ADDR_WIDTH-1:OFF_W], OFF_W'(0)};
  assign data_in        = '0;
  assign unused_bits    = ^{bus_ready, addr[OFF_W-CHUNKS_LOG-1:0], invalidate_addr[OFF_W-1:0]};

  cache_line_store #(
    .IDX_W (IDX_W),
    .TAG_W (TAG_W),
    .LINE_W(LINE_W)
  ) u_store (
    .clk      (clk),
    .reset    (reset),
    .rd_index (idx),
    .rd_valid (rd_valid),
    .rd_tag   (rd_tag),
    .rd_line  (rd_line),
    .wr_en    (fill),
    .wr_index (idx),
    .wr_tag   (tag),
    .wr_line  (data_out),
    .wr_valid (fill_valid),
    .clr_en   (invalidate),
    .clr_index(inv_idx),
    .clr_tag  (inv_tag)
  );

  always_comb begin
    state_next = state;
    addr_next  = addr;
    word_next  = word;
    fill       = 1'b0;
    fill_valid = 1'b0;
    unique case (state)
      IDLE: begin
        if (req_valid && req_ready) begin
          addr_next  = req_addr;
          state_next = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          word_next  = pick(rd_line, wsel);
          state_next = RESP;
        end else begin
          state_next = MISS;
        end
      end
      MISS: begin
        if (bus_valid) begin
          fill       = 1'b1;
          fill_valid = !inv_same;
          word_next  = pick(data_out, wsel);
          state_next = RESP;
        end
      end
      RESP: begin
        if (resp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Handshake outputs are registered from the upcoming state
    ready_next = (state_next == IDLE);
    resp_next  = (state_next == RESP);
    cmd_next   = (state_next == MISS);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      addr          <= '0;
      word          <= '0;
      req_ready     <= 1'b0;
      resp_valid    <= 1'b0;
      command_valid <= 1'b0;
    end else begin
      state         <= state_next;
      addr          <= addr_next;
      word          <= word_next;
      req_ready     <= ready_next;
      resp_valid    <= resp_next;
      command_valid <= cmd_next;
    end
  end

endmodule
